// File: rtl/mlp_cmd_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_cmd_loader_if
//  Description : Byte command stream in, MLP control/config bus out.
//                "master" is the loader side, "slave" the host/MLP side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mlp_cmd_loader_if;
  logic               in_valid;
  logic        [7:0]  in_data;
  logic               in_ready;
  logic        [3:0]  mlp_state;
  logic               wf_push_col0;
  logic               wf_push_col1;
  logic        [7:0]  wf_data_in;
  logic               wf_reset;
  logic               init_act_valid;
  logic        [15:0] init_act_data;
  logic               start_mlp;
  logic               weights_ready;
  logic signed [15:0] norm_gain;
  logic signed [31:0] norm_bias;
  logic        [4:0]  norm_shift;
  logic signed [15:0] q_inv_scale;
  logic signed [7:0]  q_zero_point;
  logic               busy;
  logic               err;
  logic        [2:0]  err_code;

  modport master (
    input  in_valid, in_data, mlp_state,
    output in_ready, wf_push_col0, wf_push_col1, wf_data_in, wf_reset,
           init_act_valid, init_act_data, start_mlp, weights_ready,
           norm_gain, norm_bias, norm_shift, q_inv_scale, q_zero_point,
           busy, err, err_code
  );

  modport slave (
    output in_valid, in_data, mlp_state,
    input  in_ready, wf_push_col0, wf_push_col1, wf_data_in, wf_reset,
           init_act_valid, init_act_data, start_mlp, weights_ready,
           norm_gain, norm_bias, norm_shift, q_inv_scale, q_zero_point,
           busy, err, err_code
  );
endinterface
`default_nettype wire

// File: rtl/mlp_cmd_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_cmd_loader
//  Description : Parses a byte-wide host command stream into weight FIFO
//                pushes, activation writes, pipeline config and the
//                start / weights-ready handshakes of the MLP datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module mlp_cmd_loader #(
  parameter int MAX_ACT_WORDS = 16,
  parameter int RDY_TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             reset,
  mlp_cmd_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_CMD       = 3'd0,
    S_W_BYTES   = 3'd1,
    S_ACT_LEN   = 3'd2,
    S_ACT_BYTES = 3'd3,
    S_CFG_BYTES = 3'd4,
    S_RDY_HOLD  = 3'd5
  } state_t;

  localparam logic [7:0]  c_max_words   = 8'(MAX_ACT_WORDS);
  localparam logic [7:0]  c_rdy_last    = 8'(RDY_TIMEOUT - 1);
  localparam logic [3:0]  c_mlp_idle    = 4'd0;
  localparam logic [3:0]  c_mlp_load_w  = 4'd1;
  localparam logic [3:0]  c_cfg_last    = 4'd9;
  localparam logic [2:0]  c_err_opcode  = 3'd1;
  localparam logic [2:0]  c_err_start   = 3'd2;
  localparam logic [2:0]  c_err_actlen  = 3'd3;
  localparam logic [2:0]  c_err_timeout = 3'd4;

  // Registered state
  state_t             r_state;
  logic        [1:0]  r_wcnt;
  logic        [4:0]  r_word_cnt;
  logic               r_act_hi;
  logic        [7:0]  r_act_lo;
  logic        [3:0]  r_cfg_cnt;
  logic        [79:0] r_shadow;
  logic        [7:0]  r_timer;
  logic               r_push0, r_push1, r_wf_reset, r_act_valid, r_start;
  logic        [7:0]  r_wf_data;
  logic        [15:0] r_act_data;
  logic               r_wready;
  logic               r_err;
  logic        [2:0]  r_err_code;
  logic signed [15:0] r_norm_gain;
  logic signed [31:0] r_norm_bias;
  logic        [4:0]  r_norm_shift;
  logic signed [15:0] r_q_inv_scale;
  logic signed [7:0]  r_q_zero_point;

  // Next-state values
  state_t             w_state;
  logic        [1:0]  w_wcnt;
  logic        [4:0]  w_word_cnt;
  logic               w_act_hi;
  logic        [7:0]  w_act_lo;
  logic        [3:0]  w_cfg_cnt;
  logic        [79:0] w_shadow;
  logic        [7:0]  w_timer;
  logic               w_push0, w_push1, w_wf_reset, w_act_valid, w_start;
  logic        [7:0]  w_wf_data;
  logic        [15:0] w_act_data;
  logic               w_wready;
  logic               w_err;
  logic        [2:0]  w_err_code;
  logic signed [15:0] w_norm_gain;
  logic signed [31:0] w_norm_bias;
  logic        [4:0]  w_norm_shift;
  logic signed [15:0] w_q_inv_scale;
  logic signed [7:0]  w_q_zero_point;

  logic               w_in_ready;
  logic               w_fire;

  // The parser only stalls the byte stream while holding weights_ready
  assign w_in_ready = (r_state != S_RDY_HOLD);
  assign w_fire     = bus.in_valid && w_in_ready;

  // Next-state and next-output decode; all strobes default low
  always_comb begin
    w_state        = r_state;
    w_wcnt         = r_wcnt;
    w_word_cnt     = r_word_cnt;
    w_act_hi       = r_act_hi;
    w_act_lo       = r_act_lo;
    w_cfg_cnt      = r_cfg_cnt;
    w_shadow       = r_shadow;
    w_timer        = r_timer;
    w_push0        = 1'b0;
    w_push1        = 1'b0;
    w_wf_reset     = 1'b0;
    w_act_valid    = 1'b0;
    w_start        = 1'b0;
    w_wf_data      = r_wf_data;
    w_act_data     = r_act_data;
    w_wready       = r_wready;
    w_err          = r_err;
    w_err_code     = r_err_code;
    w_norm_gain    = r_norm_gain;
    w_norm_bias    = r_norm_bias;
    w_norm_shift   = r_norm_shift;
    w_q_inv_scale  = r_q_inv_scale;
    w_q_zero_point = r_q_zero_point;

    case (r_state)
      S_CMD: begin
        if (w_fire) begin
          case (bus.in_data)
            8'h00: ;
            8'h01: begin
              w_state = S_W_BYTES;
              w_wcnt  = 2'd0;
            end
            8'h02: w_state = S_ACT_LEN;
            8'h03: begin
              if (bus.mlp_state == c_mlp_idle) begin
                w_start = 1'b1;
              end else begin
                w_err      = 1'b1;
                w_err_code = c_err_start;
              end
            end
            8'h04: begin
              w_state  = S_RDY_HOLD;
              w_wready = 1'b1;
              w_timer  = 8'd0;
            end
            8'h05: w_wf_reset = 1'b1;
            8'h06: begin
              w_state   = S_CFG_BYTES;
              w_cfg_cnt = 4'd0;
            end
            8'h07: begin
              w_err      = 1'b0;
              w_err_code = 3'd0;
            end
            default: begin
              w_err      = 1'b1;
              w_err_code = c_err_opcode;
            end
          endcase
        end
      end

      S_W_BYTES: begin
        if (w_fire) begin
          w_wf_data = bus.in_data;
          w_push0   = ~r_wcnt[1];
          w_push1   = r_wcnt[1];
          w_wcnt    = r_wcnt + 2'd1;
          if (r_wcnt == 2'd3) begin
            w_state = S_CMD;
          end
        end
      end

      S_ACT_LEN: begin
        if (w_fire) begin
          if ((bus.in_data == 8'd0) || (bus.in_data > c_max_words)) begin
            w_err      = 1'b1;
            w_err_code = c_err_actlen;
            w_state    = S_CMD;
          end else begin
            w_word_cnt = bus.in_data[4:0];
            w_act_hi   = 1'b0;
            w_state    = S_ACT_BYTES;
          end
        end
      end

      S_ACT_BYTES: begin
        if (w_fire) begin
          if (!r_act_hi) begin
            w_act_lo = bus.in_data;
            w_act_hi = 1'b1;
          end else begin
            w_act_valid = 1'b1;
            w_act_data  = {bus.in_data, r_act_lo};
            w_act_hi    = 1'b0;
            w_word_cnt  = r_word_cnt - 5'd1;
            if (r_word_cnt == 5'd1) begin
              w_state = S_CMD;
            end
          end
        end
      end

      S_CFG_BYTES: begin
        if (w_fire) begin
          w_shadow[{r_cfg_cnt, 3'b000} +: 8] = bus.in_data;
          w_cfg_cnt = r_cfg_cnt + 4'd1;
          // Live registers change only once the full record is in
          if (r_cfg_cnt == c_cfg_last) begin
            w_norm_gain    = w_shadow[15:0];
            w_norm_bias    = w_shadow[47:16];
            w_norm_shift   = w_shadow[52:48];
            w_q_inv_scale  = w_shadow[71:56];
            w_q_zero_point = w_shadow[79:72];
            w_state        = S_CMD;
          end
        end
      end

      S_RDY_HOLD: begin
        if (bus.mlp_state == c_mlp_load_w) begin
          w_wready = 1'b0;
          w_state  = S_CMD;
        end else if (r_timer >= c_rdy_last) begin
          w_wready   = 1'b0;
          w_err      = 1'b1;
          w_err_code = c_err_timeout;
          w_state    = S_CMD;
        end else begin
          w_timer = r_timer + 8'd1;
        end
      end

      default: w_state = S_CMD;
    endcase
  end

  // State and output registers; reset discards any partial command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_CMD;
      r_wcnt         <= 2'd0;
      r_word_cnt     <= 5'd0;
      r_act_hi       <= 1'b0;
      r_act_lo       <= 8'd0;
      r_cfg_cnt      <= 4'd0;
      r_shadow       <= 80'd0;
      r_timer        <= 8'd0;
      r_push0        <= 1'b0;
      r_push1        <= 1'b0;
      r_wf_reset     <= 1'b0;
      r_act_valid    <= 1'b0;
      r_start        <= 1'b0;
      r_wf_data      <= 8'd0;
      r_act_data     <= 16'd0;
      r_wready       <= 1'b0;
      r_err          <= 1'b0;
      r_err_code     <= 3'd0;
      r_norm_gain    <= 16'sh0100;
      r_norm_bias    <= 32'sd0;
      r_norm_shift   <= 5'd8;
      r_q_inv_scale  <= 16'sh0100;
      r_q_zero_point <= 8'sd0;
    end else begin
      r_state        <= w_state;
      r_wcnt         <= w_wcnt;
      r_word_cnt     <= w_word_cnt;
      r_act_hi       <= w_act_hi;
      r_act_lo       <= w_act_lo;
      r_cfg_cnt      <= w_cfg_cnt;
      r_shadow       <= w_shadow;
      r_timer        <= w_timer;
      r_push0        <= w_push0;
      r_push1        <= w_push1;
      r_wf_reset     <= w_wf_reset;
      r_act_valid    <= w_act_valid;
      r_start        <= w_start;
      r_wf_data      <= w_wf_data;
      r_act_data     <= w_act_data;
      r_wready       <= w_wready;
      r_err          <= w_err;
      r_err_code     <= w_err_code;
      r_norm_gain    <= w_norm_gain;
      r_norm_bias    <= w_norm_bias;
      r_norm_shift   <= w_norm_shift;
      r_q_inv_scale  <= w_q_inv_scale;
      r_q_zero_point <= w_q_zero_point;
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.wf_push_col0   = r_push0;
  assign bus.wf_push_col1   = r_push1;
  assign bus.wf_data_in     = r_wf_data;
  assign bus.wf_reset       = r_wf_reset;
  assign bus.init_act_valid = r_act_valid;
  assign bus.init_act_data  = r_act_data;
  assign bus.start_mlp      = r_start;
  assign bus.weights_ready  = r_wready;
  assign bus.norm_gain      = r_norm_gain;
  assign bus.norm_bias      = r_norm_bias;
  assign bus.norm_shift     = r_norm_shift;
  assign bus.q_inv_scale    = r_q_inv_scale;
  assign bus.q_zero_point   = r_q_zero_point;
  assign bus.busy           = (r_state != S_CMD);
  assign bus.err            = r_err;
  assign bus.err_code       = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_mlp_cmd_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mlp_cmd_loader
//  Description : Directed self-checking bench for mlp_cmd_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_cmd_loader;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  mlp_cmd_loader_if bus ();

  mlp_cmd_loader #(
    .MAX_ACT_WORDS (16),
    .RDY_TIMEOUT   (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bound on total run time
  initial begin
    #500000;
    $display("FAIL watchdog: observed run still active, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Present one byte; returns 1 ns after the consuming edge
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cfg_reset(input string tag);
    chk({tag, "_gain"},  {16'd0, bus.norm_gain},    32'h0100);
    chk({tag, "_bias"},  bus.norm_bias,             32'h0);
    chk({tag, "_shift"}, {27'd0, bus.norm_shift},   32'd8);
    chk({tag, "_qinv"},  {16'd0, bus.q_inv_scale},  32'h0100);
    chk({tag, "_qzp"},   {24'd0, bus.q_zero_point}, 32'h0);
  endtask

  initial begin
    logic [7:0] cfg_bytes [10];
    int         act_cnt;
    int         hi_cnt;
    logic       act_ok;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.mlp_state = 4'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_err", {28'd0, bus.err, bus.err_code}, 32'd0);
    chk("rst_wready", {31'd0, bus.weights_ready}, 32'd0);
    chk("rst_strobes", {27'd0, bus.wf_push_col0, bus.wf_push_col1, bus.wf_reset,
                        bus.init_act_valid, bus.start_mlp}, 32'd0);
    chk_cfg_reset("rst");
    @(negedge clk);
    reset = 1'b0;

    // 1. Weight load: 01 11 22 33 44
    send(8'h01);
    chk("w_busy", {31'd0, bus.busy}, 32'd1);
    send(8'h11);
    chk("w_b0", {22'd0, bus.wf_push_col0, bus.wf_push_col1, bus.wf_data_in}, {22'd0, 2'b10, 8'h11});
    idle();
    chk("w_b0_pulse", {30'd0, bus.wf_push_col0, bus.wf_push_col1}, 32'd0);
    send(8'h22);
    chk("w_b1", {22'd0, bus.wf_push_col0, bus.wf_push_col1, bus.wf_data_in}, {22'd0, 2'b10, 8'h22});
    send(8'h33);
    chk("w_b2", {22'd0, bus.wf_push_col0, bus.wf_push_col1, bus.wf_data_in}, {22'd0, 2'b01, 8'h33});
    send(8'h44);
    chk("w_b3", {22'd0, bus.wf_push_col0, bus.wf_push_col1, bus.wf_data_in}, {22'd0, 2'b01, 8'h44});
    chk("w_done_busy", {31'd0, bus.busy}, 32'd0);
    idle();
    chk("w_b3_pulse", {30'd0, bus.wf_push_col0, bus.wf_push_col1}, 32'd0);

    // 2. Activations: 02 02 05 03 07 01
    send(8'h02);
    send(8'h02);
    send(8'h05);
    chk("a_lo0", {31'd0, bus.init_act_valid}, 32'd0);
    send(8'h03);
    chk("a_w0", {15'd0, bus.init_act_valid, bus.init_act_data}, {15'd0, 1'b1, 16'h0305});
    send(8'h07);
    chk("a_lo1", {31'd0, bus.init_act_valid}, 32'd0);
    send(8'h01);
    chk("a_w1", {15'd0, bus.init_act_valid, bus.init_act_data}, {15'd0, 1'b1, 16'h0107});
    chk("a_done_busy", {31'd0, bus.busy}, 32'd0);
    idle();
    chk("a_w1_pulse", {31'd0, bus.init_act_valid}, 32'd0);

    // 3. Bad activation lengths 0 and 17
    send(8'h02);
    send(8'h00);
    chk("len0", {27'd0, bus.init_act_valid, bus.busy, bus.err, bus.err_code}, {27'd0, 2'b00, 1'b1, 3'd3});
    send(8'h07);
    chk("clr", {28'd0, bus.err, bus.err_code}, 32'd0);
    send(8'h02);
    send(8'h11);
    chk("len17", {27'd0, bus.init_act_valid, bus.busy, bus.err, bus.err_code}, {27'd0, 2'b00, 1'b1, 3'd3});
    send(8'h07);
    chk("clr_after_len17", {28'd0, bus.err, bus.err_code}, 32'd0);

    // Maximum length (16 words) is accepted
    send(8'h02);
    send(8'h10);
    act_cnt = 0;
    act_ok  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      if (bus.init_act_valid) act_cnt++;
      send(8'hA0 + 8'(i));
      if (!bus.init_act_valid || bus.init_act_data != {8'hA0 + 8'(i), 8'(i)}) act_ok = 1'b0;
      else act_cnt++;
    end
    chk("len16_count", act_cnt, 32'd16);
    chk("len16_data", {31'd0, act_ok}, 32'd1);
    chk("len16_done", {28'd0, bus.busy, bus.err_code}, 32'd0);

    // 4. START with idle and busy MLP
    bus.mlp_state = 4'd0;
    send(8'h03);
    chk("start_pulse", {31'd0, bus.start_mlp}, 32'd1);
    idle();
    chk("start_1cyc", {31'd0, bus.start_mlp}, 32'd0);
    bus.mlp_state = 4'd3;
    send(8'h03);
    chk("start_busy", {27'd0, bus.start_mlp, bus.err, bus.err_code}, {27'd0, 1'b0, 1'b1, 3'd2});

    // Bad opcode, then error overwrite
    send(8'h07);
    send(8'h09);
    chk("bad_op", {28'd0, bus.err, bus.err_code}, {28'd0, 1'b1, 3'd1});
    send(8'h03);
    chk("err_overwrite", {28'd0, bus.err, bus.err_code}, {28'd0, 1'b1, 3'd2});
    send(8'h07);
    send(8'h05);
    chk("wf_reset", {31'd0, bus.wf_reset}, 32'd1);
    idle();
    chk("wf_reset_1cyc", {31'd0, bus.wf_reset}, 32'd0);

    // 5a. weights_ready released by LOAD_WEIGHT
    bus.mlp_state = 4'd7;
    send(8'h04);
    hi_cnt = (bus.weights_ready && !bus.in_ready) ? 1 : 0;
    repeat (5) begin
      idle();
      if (bus.weights_ready && !bus.in_ready) hi_cnt++;
    end
    @(negedge clk);
    bus.mlp_state = 4'd1;
    idle();
    chk("rdy_high_cycles", hi_cnt, 32'd6);
    chk("rdy_release", {28'd0, bus.weights_ready, bus.in_ready, bus.busy, bus.err}, {28'd0, 4'b0100});

    // 5b. weights_ready timeout
    bus.mlp_state = 4'd7;
    send(8'h04);
    hi_cnt = bus.weights_ready ? 1 : 0;
    for (int i = 0; i < 400 && bus.weights_ready; i++) begin
      idle();
      if (bus.weights_ready) hi_cnt++;
    end
    chk("rdy_timeout_cycles", hi_cnt, 32'd255);
    chk("rdy_timeout_err", {27'd0, bus.weights_ready, bus.err, bus.err_code}, {27'd0, 1'b0, 1'b1, 3'd4});
    bus.mlp_state = 4'd0;
    send(8'h07);

    // 6. Config load, atomic update
    cfg_bytes = '{8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0A, 8'h80, 8'h00, 8'hFE};
    send(8'h06);
    for (int i = 0; i < 9; i++) send(cfg_bytes[i]);
    chk_cfg_reset("cfg_partial");
    send(cfg_bytes[9]);
    chk("cfg_gain",  {16'd0, bus.norm_gain},    32'h0200);
    chk("cfg_bias",  bus.norm_bias,             32'h12345678);
    chk("cfg_shift", {27'd0, bus.norm_shift},   32'd10);
    chk("cfg_qinv",  {16'd0, bus.q_inv_scale},  32'h0080);
    chk("cfg_qzp",   {24'd0, bus.q_zero_point}, 32'h000000FE);
    chk("cfg_done_busy", {31'd0, bus.busy}, 32'd0);

    // Reset in the middle of a config record
    send(8'h06);
    for (int i = 0; i < 5; i++) send(8'h11 * 8'(i + 1));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_cfg_reset("cfg_midrst");
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);

    // A byte offered during reset is dropped
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h09;
    idle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle();
    chk("rst_drop_byte", {27'd0, bus.busy, bus.err, bus.err_code}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mlp_cmd_loader.md
Name: mlp_cmd_loader

Overview:
- Upstream host-side front end for the MLP datapath.
- Parses a byte-wide command stream (from the UART RX / host bridge) into the MLP control interface:
  - weight FIFO pushes
  - initial activation writes into unified buffer A
  - activation-pipeline configuration registers
  - the start_mlp / weights_ready handshakes
- Watches the MLP FSM state so that start and weight-ready commands are issued only when the datapath can accept them.

Parameters:
MAX_ACT_WORDS, 16, max 16-bit activation words per LOAD_ACT (equals UB depth)
RDY_TIMEOUT, 255, cycles weights_ready is held before abort with error

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
in_valid  input  1  command byte valid
in_data  input  8  command byte
in_ready  output  1  byte accepted when in_valid && in_ready
mlp_state  input  4  MLP FSM state (0 IDLE, 1 LOAD_WEIGHT, 7 WAIT_WEIGHTS)
wf_push_col0  output  1  push wf_data_in into weight column 0
wf_push_col1  output  1  push wf_data_in into weight column 1
wf_data_in  output  8  weight byte
wf_reset  output  1  weight FIFO clear pulse
init_act_valid  output  1  activation word write strobe
init_act_data  output  16  {row1, row0} activation word
start_mlp  output  1  one-cycle start pulse
weights_ready  output  1  next-layer weights present (level)
norm_gain  output  16 signed  config register
norm_bias  output  32 signed  config register
norm_shift  output  5  config register
q_inv_scale  output  16 signed  config register
q_zero_point  output  8 signed  config register
busy  output  1  parser not in CMD state
err  output  1  sticky error flag, cleared by opcode 0x07
err_code  output  3  last error: 1 bad opcode, 2 start while MLP busy, 3 bad act length, 4 ready timeout

Behaviour:
- Reset (async, any state): parser to CMD; all strobes/pulses 0; weights_ready 0; err 0; err_code 0; in_ready 1.
- Reset config values:
  - norm_gain 0x0100
  - norm_bias 0
  - norm_shift 8
  - q_inv_scale 0x0100
  - q_zero_point 0
- A byte is consumed on every cycle with in_valid && in_ready.
- in_ready is 1 in every state except RDY_HOLD.
- Every output strobe is registered: asserted the cycle after the consuming byte, for exactly 1 cycle.
- States:
  - CMD: decode opcode
    - 0x01 → W_BYTES (count 0)
    - 0x02 → ACT_LEN
    - 0x03 START: if mlp_state==0, pulse start_mlp; else err=1, code 2, no pulse. Stay in CMD.
    - 0x04 → RDY_HOLD: weights_ready=1, timer cleared
    - 0x05 WF_CLR: pulse wf_reset
    - 0x06 → CFG_BYTES (count 0)
    - 0x07: clear err and err_code
    - 0x00: no-op
    - anything else: err=1, code 1, stay in CMD
  - W_BYTES: 4 bytes.
    - Bytes 0,1 → wf_push_col0 with wf_data_in = byte.
    - Bytes 2,3 → wf_push_col1.
    - After byte 3 → CMD.
  - ACT_LEN: byte K.
    - K==0 or K>MAX_ACT_WORDS: err=1, code 3, → CMD.
    - Otherwise → ACT_BYTES with word count K.
  - ACT_BYTES:
    - Bytes arrive low then high.
    - After each high byte: init_act_valid=1, init_act_data={high,low}, word count decrements.
    - → CMD after word K is written.
    - Exactly K strobes per command; no strobe on a low byte.
  - CFG_BYTES: 10 bytes, little-endian, loaded into shadow regs in this order: norm_gain(2), norm_bias(4), norm_shift(1, bits[4:0]), q_inv_scale(2), q_zero_point(1).
    - Outputs update atomically on the cycle after byte 9.
    - Outputs never show partial values.
  - RDY_HOLD: in_ready=0, weights_ready=1, timer increments every cycle.
    - mlp_state==1 observed → weights_ready=0 next cycle, → CMD.
    - Timer reaches RDY_TIMEOUT first → weights_ready=0, err=1, code 4, → CMD.
- Stream has no framing resync; the host recovers from a bad opcode by sending 0x00 padding.
- A new error overwrites err_code; err stays 1.
- Simultaneous in_valid with reset: byte dropped.
- Reset mid-command: partial weights/activations are discarded, config shadow is discarded, live config returns to reset values.
- busy = (state != CMD).
- Counters: 2-bit weight count, 4-bit config count, 5-bit word count, 8-bit timer (saturates at RDY_TIMEOUT).

Test Plan:
1. Bytes 01 11 22 33 44 → wf_push_col0 with 0x11, then 0x22; wf_push_col1 with 0x33, then 0x44; each 1 cycle; then back to CMD.
2. Bytes 02 02 05 03 07 01 → init_act_valid twice, data 0x0305 then 0x0107; no strobe on low bytes.
3. Byte 02 then 00, and 02 then 11 (17) → no init_act_valid; err=1, err_code=3; parser back in CMD and accepts next opcode.
4. Byte 03 with mlp_state=0 → start_mlp pulse 1 cycle. Byte 03 with mlp_state=3 → no pulse, err_code=2.
5. Byte 04 with mlp_state=7 for 5 cycles then 1 → weights_ready high 6 cycles, in_ready low meanwhile, then drops. Byte 04 with mlp_state held at 7 → timeout after 255 cycles, err_code=4.
6. Bytes 06 00 02 78 56 34 12 0A 80 00 FE → outputs update together: norm_gain 0x0200, norm_bias 0x12345678, norm_shift 10, q_inv_scale 0x0080, q_zero_point −2. Reset asserted after only 5 of the 10 config bytes → config returns to reset values.
